// File: rtl/fe_capture_packer_pkg.sv
// Shared definitions for the capture packer: FIFO word layout, command codes and FSM states.
package fe_capture_packer_pkg;

    localparam int WORD_W    = 18;
    localparam int CMD_MSB   = 17;
    localparam int CMD_LSB   = 16;
    localparam int PAYLOAD_W = 16;

    // Code 2'b11 is reserved and never emitted.
    typedef enum logic [1:0] {
        CMD_DATA = 2'b00,
        CMD_STAT = 2'b01,
        CMD_TIME = 2'b10
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ARMED     = 2'b01,
        ST_CAPTURING = 2'b10,
        ST_DONE      = 2'b11
    } state_t;

    function automatic logic [WORD_W-1:0] pack_word(input cmd_t cmd,
                                                    input logic [PAYLOAD_W-1:0] payload);
        logic [WORD_W-1:0] w;
        w                    = '0;
        w[CMD_MSB:CMD_LSB]   = cmd;
        w[PAYLOAD_W-1:0]     = payload;
        return w;
    endfunction

endpackage

// File: rtl/fe_capture_packer_if.sv
// Capture FIFO write port as seen from the packer (master) and the FIFO (slave).
// O_fifo_wr is a one-cycle strobe qualifying O_fifo_data; there is no ready --
// I_fifo_prog_full is the only back-pressure and is honoured when a word is sampled.
interface fe_capture_packer_if;
    import fe_capture_packer_pkg::*;

    logic [WORD_W-1:0] O_fifo_data;
    logic              O_fifo_wr;
    logic              I_fifo_prog_full;

    modport master (output O_fifo_data, output O_fifo_wr, input I_fifo_prog_full);
    modport slave  (input O_fifo_data, input O_fifo_wr, output I_fifo_prog_full);
endinterface

// File: rtl/fe_packer_delta_timer.sv
// Saturating inter-word delta counter; clear has priority over load-1, which beats increment.
module fe_packer_delta_timer #(
    parameter int DELTA_W = 8
) (
    input  logic               fe_clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               load_one,
    input  logic               inc,
    output logic [DELTA_W-1:0] delta,
    output logic               at_max
);

    logic [DELTA_W-1:0] cnt_q;

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (load_one) begin
            cnt_q <= DELTA_W'(1);
        end else if (inc && !at_max) begin
            cnt_q <= cnt_q + DELTA_W'(1);
        end
    end

    assign delta  = cnt_q;
    assign at_max = &cnt_q;

endmodule

// File: rtl/fe_capture_packer.sv
// Packs front-end events into timestamped capture FIFO words and runs arm/trigger/capture/done.
// STAT word generation from I_stat changes is built only when PACKER_STAT_EN is defined.
module fe_capture_packer
    import fe_capture_packer_pkg::*;
#(
    parameter int DELTA_W = 8,
    parameter int LEN_W   = 16
) (
    input  logic                       fe_clk,
    input  logic                       reset_n,
    input  logic                       I_arm,
    input  logic                       I_trigger,
    input  logic [LEN_W-1:0]           I_capture_len,
    input  logic                       I_event_valid,
    input  logic [7:0]                 I_event_data,
    input  logic [2:0]                 I_stat,
    fe_capture_packer_if.master        fifo,
    output logic                       O_capturing,
    output logic                       O_capture_done,
    output logic                       O_overflow,
    output logic [LEN_W-1:0]           O_word_count,
    output state_t                     dbg_state
);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, count_q;
    logic [LEN_W:0]     count_next;
    logic               overflow_q, wr_q;
    logic [WORD_W-1:0]  data_q, word_d;
    logic               cand, is_stat, do_write, set_ovf;
    logic [DELTA_W-1:0] delta;
    logic               at_max;
    logic               pend_q;
    logic [2:0]         pend_val_q;

    assign count_next = {1'b0, count_q} + {{LEN_W{1'b0}}, 1'b1};

    fe_packer_delta_timer #(.DELTA_W(DELTA_W)) u_delta (
        .fe_clk   (fe_clk),
        .reset_n  (reset_n),
        .clear    (state_q == ST_ARMED && I_trigger && !I_arm),
        .load_one (cand),
        .inc      (state_q == ST_CAPTURING),
        .delta    (delta),
        .at_max   (at_max)
    );

`ifdef PACKER_STAT_EN
    logic [2:0] stat_prev_q;

    // Latest change wins: a newer status overwrites a pending one before it is emitted.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_prev_q <= '0;
            pend_q      <= 1'b0;
            pend_val_q  <= '0;
        end else if (I_arm) begin
            stat_prev_q <= I_stat;
            pend_q      <= 1'b0;
        end else if (state_q == ST_ARMED) begin
            stat_prev_q <= I_stat;
        end else if (state_q == ST_CAPTURING) begin
            if (I_stat != stat_prev_q) begin
                stat_prev_q <= I_stat;
                pend_q      <= 1'b1;
                pend_val_q  <= I_stat;
            end else if (do_write && is_stat) begin
                pend_q <= 1'b0;
            end
        end
    end
`else
    logic unused_stat;
    assign unused_stat = ^{I_stat, is_stat};
    assign pend_q      = 1'b0;
    assign pend_val_q  = '0;
`endif

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // One candidate per CAPTURING cycle: DATA, then pending STAT, then TIME at delta saturation.
    always_comb begin
        state_d  = state_q;
        cand     = 1'b0;
        is_stat  = 1'b0;
        word_d   = '0;
        do_write = 1'b0;
        set_ovf  = 1'b0;
        if (I_arm) begin
            state_d = ST_ARMED;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ARMED: begin
                    if (I_trigger) state_d = ST_CAPTURING;
                end
                ST_CAPTURING: begin
                    if (I_event_valid) begin
                        cand   = 1'b1;
                        word_d = pack_word(CMD_DATA, {8'(delta), I_event_data});
                    end else if (pend_q) begin
                        cand    = 1'b1;
                        is_stat = 1'b1;
                        word_d  = pack_word(CMD_STAT, {13'd0, pend_val_q});
                    end else if (at_max) begin
                        cand   = 1'b1;
                        word_d = pack_word(CMD_TIME, 16'd0);
                    end
                    if (cand) begin
                        if (fifo.I_fifo_prog_full) begin
                            set_ovf = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            do_write = 1'b1;
                            if (len_q != '0 && count_next == {1'b0, len_q}) state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // The write register is not touched by arm, so a word sampled before arm still goes out.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q       <= 1'b0;
            data_q     <= '0;
            len_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_q <= do_write;
            if (do_write) data_q <= word_d;
            if (I_arm) begin
                len_q      <= I_capture_len;
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (do_write && count_q != '1) count_q <= count_next[LEN_W-1:0];
                if (set_ovf) overflow_q <= 1'b1;
            end
        end
    end

    assign fifo.O_fifo_wr   = wr_q;
    assign fifo.O_fifo_data = data_q;
    assign O_capturing      = (state_q == ST_CAPTURING);
    assign O_capture_done   = (state_q == ST_DONE);
    assign O_overflow       = overflow_q;
    assign O_word_count     = count_q;
    assign dbg_state        = state_q;

endmodule
